// File: rtl/m2_pwr_seq.sv
// M2 power sequencer: drives the power switch and isolation clamp, gates M1->M2 ready,
// and drains execute activity before isolating and removing power.
module m2_pwr_seq #(
    parameter int ACK_TIMEOUT   = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 2
) (
    input  logic ck,
    input  logic arst,
    input  logic pup_req,
    input  logic pdn_req,
    input  logic clr_err,
    input  logic pwr_ack,
    input  logic ready_in,
    input  logic execute_in,
    output logic ready_gated,
    output logic isolateM1M2,
    output logic pwr_en,
    output logic on,
    output logic busy,
    output logic err
);
    localparam int MAX_AS = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_C  = (MAX_AS > DRAIN_CYCLES) ? MAX_AS : DRAIN_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PUP    = 3'd1,
        S_SETTLE = 3'd2,
        S_ON     = 3'd3,
        S_DRAIN  = 3'd4,
        S_ISO    = 3'd5,
        S_PDN    = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_n;
    logic            iso_q, pwr_en_q, on_q, busy_q, err_q;

    // Output decode {iso, pwr_en, on, busy, err}; unknown encodings fall back to a clamped, unpowered state
    function automatic logic [4:0] outs_of(input state_t s);
        case (s)
            S_OFF:    outs_of = 5'b10000;
            S_PUP:    outs_of = 5'b11010;
            S_SETTLE: outs_of = 5'b11010;
            S_ON:     outs_of = 5'b01100;
            S_DRAIN:  outs_of = 5'b01010;
            S_ISO:    outs_of = 5'b11010;
            S_PDN:    outs_of = 5'b10010;
            S_FAULT:  outs_of = 5'b10001;
            default:  outs_of = 5'b10001;
        endcase
    endfunction

    // Next-state and shared counter logic; counter clears whenever the state changes
    always_comb begin
        state_d = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            S_OFF: begin
                if (pup_req) state_d = S_PUP;
                else         state_d = S_OFF;
            end
            S_PUP: begin
                if (pwr_ack)                               state_d = S_SETTLE;
                else if (cnt_q == CW'(ACK_TIMEOUT - 1))    state_d = S_FAULT;
                else                                       cnt_n   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
            S_SETTLE: begin
                if (!pwr_ack)                              state_d = S_FAULT;
                else if (cnt_q == CW'(SETTLE_CYCLES - 1))  state_d = S_ON;
                else                                       cnt_n   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
            S_ON: begin
                if (!pwr_ack)     state_d = S_FAULT;
                else if (pdn_req) state_d = S_DRAIN;
                else              state_d = S_ON;
            end
            S_DRAIN: begin
                // Only an unbroken run of idle cycles counts toward the drain
                if (execute_in)                            cnt_n   = {CW{1'b0}};
                else if (cnt_q == CW'(DRAIN_CYCLES - 1))   state_d = S_ISO;
                else                                       cnt_n   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
            S_ISO: begin
                state_d = S_PDN;
            end
            S_PDN: begin
                if (!pwr_ack)                              state_d = S_OFF;
                else if (cnt_q == CW'(ACK_TIMEOUT - 1))    state_d = S_FAULT;
                else                                       cnt_n   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
            S_FAULT: begin
                if (clr_err) state_d = S_OFF;
                else         state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
        if (state_d != state_q) cnt_d = {CW{1'b0}};
        else                    cnt_d = cnt_n;
    end

    // State, counter and outputs registered together so outputs always reflect the held state
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state_q  <= S_OFF;
            cnt_q    <= {CW{1'b0}};
            iso_q    <= 1'b1;
            pwr_en_q <= 1'b0;
            on_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            {iso_q, pwr_en_q, on_q, busy_q, err_q} <= outs_of(state_d);
        end
    end

    assign ready_gated = ready_in & on_q;
    assign isolateM1M2 = iso_q;
    assign pwr_en      = pwr_en_q;
    assign on          = on_q;
    assign busy        = busy_q;
    assign err         = err_q;

    m2_pwr_seq_chk u_chk (
        .ck          (ck),
        .arst        (arst),
        .iso         (iso_q),
        .pwr_en      (pwr_en_q),
        .ready_gated (ready_gated),
        .in_on       (state_q == S_ON),
        .in_on_drain ((state_q == S_ON) || (state_q == S_DRAIN))
    );
endmodule

// Safety invariants on the clamp, power enable and ready gating.
module m2_pwr_seq_chk (
    input logic ck,
    input logic arst,
    input logic iso,
    input logic pwr_en,
    input logic ready_gated,
    input logic in_on,
    input logic in_on_drain
);
    a_unpowered_isolated: assert property (@(posedge ck) disable iff (arst) !pwr_en |-> iso);
    a_unclamped_states:   assert property (@(posedge ck) disable iff (arst) !iso |-> in_on_drain);
    a_ready_only_on:      assert property (@(posedge ck) disable iff (arst) ready_gated |-> in_on);
endmodule
